fma_arbiter: RTL and testbench

Shares the single VALUE_MN-lane FMA array between up to N_REQ sequencing controllers, such as the FFN multiply, SiLU and normalisation controllers. Requesters drive their own mode/a/b operand buses. The arbiter grants one requester at a time for a bounded burst and muxes that requester's operands onto the FMA inputs. It tracks in-flight issues through the FMA pipeline and returns each result to the requester that issued it, with a per-requester valid.

---
 rtl/fma_arbiter.sv | 155 +++++++++++++++
 tb/tb_fma_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_arbiter.sv
// fma_arbiter: burst-granting mux that shares one FMA array among N_REQ requesters.
// Define FMA_ARB_FIXED_PRIO_EN for fixed priority; round-robin otherwise.
module fma_arbiter #(
    parameter int BW_FP    = 17,
    parameter int VALUE_MN = 64,
    parameter int N_REQ    = 4,
    parameter int FMA_LAT  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*4-1:0]              hold_len,
    input  logic [N_REQ*VALUE_MN*5-1:0]     mode_in,
    input  logic [N_REQ*VALUE_MN*BW_FP-1:0] a_in,
    input  logic [N_REQ*VALUE_MN*BW_FP-1:0] b_in,
    input  logic [VALUE_MN*BW_FP-1:0]       fma_out,
    output logic [N_REQ-1:0]                gnt,
    output logic                            busy,
    output logic [VALUE_MN*5-1:0]           fma_mode,
    output logic [VALUE_MN*BW_FP-1:0]       fma_a,
    output logic [VALUE_MN*BW_FP-1:0]       fma_b,
    output logic [VALUE_MN*BW_FP-1:0]       rsp_data,
    output logic [N_REQ-1:0]                rsp_valid
);
    localparam int IW = $clog2(N_REQ);
    localparam int DW = VALUE_MN * BW_FP;
    localparam int MW = VALUE_MN * 5;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [IW-1:0]      own_q, own_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               issue, rearb;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [FMA_LAT-1:0] sr_v;
    logic [IW-1:0]      sr_o [FMA_LAT];

`ifdef FMA_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr_q;
    logic [IW:0]   j;

    // Scan from farthest to nearest so the entry after ptr_q wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = {1'b0, ptr_q} + (IW+1)'(k);
            if (j >= (IW+1)'(N_REQ))
                j = j - (IW+1)'(N_REQ);
            if (req[j[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = j[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= IW'(N_REQ - 1);
        else if (rearb && win_found)
            ptr_q <= win_idx;
    end
`endif

    always_comb begin
        issue    = 1'b0;
        fma_mode = '0;
        fma_a    = '0;
        fma_b    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i] && req[i]) begin
                issue    = 1'b1;
                fma_mode = mode_in[i*MW +: MW];
                fma_a    = a_in[i*DW +: DW];
                fma_b    = b_in[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        own_d   = own_q;
        cnt_d   = cnt_q;
        rearb   = 1'b0;
        unique case (state_q)
            IDLE: rearb = 1'b1;
            GRANT: begin
                if (issue)
                    cnt_d = cnt_q - 4'd1;
                rearb = !issue || (cnt_q == 4'd0);
            end
            default: rearb = 1'b1;
        endcase
        if (rearb) begin
            if (win_found) begin
                state_d = GRANT;
                gnt_d   = N_REQ'(1) << win_idx;
                own_d   = win_idx;
                cnt_d   = hold_len[4*win_idx +: 4];
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            own_q     <= '0;
            cnt_q     <= '0;
            sr_v      <= '0;
            for (int i = 0; i < FMA_LAT; i++)
                sr_o[i] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            sr_v[0] <= issue;
            sr_o[0] <= own_q;
            for (int i = 1; i < FMA_LAT; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_o[i] <= sr_o[i-1];
            end
            rsp_valid <= sr_v[FMA_LAT-1] ?
                         (N_REQ'(1) << sr_o[FMA_LAT-1]) : '0;
            if (sr_v[FMA_LAT-1])
                rsp_data <= fma_out;
        end
    end

    assign busy = (state_q == GRANT) || (|sr_v);

endmodule

// File: tb/tb_fma_arbiter.sv
// Bench for fma_arbiter: directed literal scenarios plus randomized traffic
// checked every cycle against a cycle-level behavioural model.
module tb_fma_arbiter;
    localparam int BW_FP    = 17;
    localparam int VALUE_MN = 64;
    localparam int N_REQ    = 4;
    localparam int FMA_LAT  = 2;
    localparam int DW       = VALUE_MN * BW_FP;
    localparam int MW       = VALUE_MN * 5;

    logic                            clk;
    logic                            rst_n;
    logic [N_REQ-1:0]                req;
    logic [N_REQ*4-1:0]              hold_len;
    logic [N_REQ*MW-1:0]             mode_in;
    logic [N_REQ*DW-1:0]             a_in;
    logic [N_REQ*DW-1:0]             b_in;
    logic [DW-1:0]                   fma_out;
    logic [N_REQ-1:0]                gnt;
    logic                            busy;
    logic [MW-1:0]                   fma_mode;
    logic [DW-1:0]                   fma_a;
    logic [DW-1:0]                   fma_b;
    logic [DW-1:0]                   rsp_data;
    logic [N_REQ-1:0]                rsp_valid;

    fma_arbiter #(
        .BW_FP(BW_FP), .VALUE_MN(VALUE_MN), .N_REQ(N_REQ), .FMA_LAT(FMA_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .hold_len(hold_len),
        .mode_in(mode_in), .a_in(a_in), .b_in(b_in), .fma_out(fma_out),
        .gnt(gnt), .busy(busy), .fma_mode(fma_mode), .fma_a(fma_a),
        .fma_b(fma_b), .rsp_data(rsp_data), .rsp_valid(rsp_valid)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 100;

    // model state
    int            m_own  = -1;
    int            m_left = 0;
    int            m_ptr  = N_REQ - 1;
    logic [DW-1:0] m_rsp  = '0;
    int            iss_r [8];
    logic [DW-1:0] fo_r  [8];

    localparam logic [3:0] G1 [7] = '{0, 2, 2, 2, 2, 2, 2};
    localparam logic [3:0] V1 [7] = '{0, 0, 0, 0, 2, 2, 2};
    localparam logic [3:0] G3 [8] = '{0, 4, 4, 4, 4, 1, 1, 1};
    localparam logic [3:0] V3 [8] = '{0, 0, 0, 0, 4, 4, 4, 0};
`ifdef FMA_ARB_FIXED_PRIO_EN
    localparam logic [3:0] G2 [6] = '{0, 1, 1, 1, 1, 1};
    localparam logic [3:0] G4 [8] = '{0, 1, 1, 1, 8, 8, 0, 0};
    localparam logic [3:0] V4 [8] = '{0, 0, 0, 0, 1, 1, 0, 8};
`else
    localparam logic [3:0] G2 [6] = '{0, 1, 2, 4, 8, 1};
    localparam logic [3:0] G4 [8] = '{0, 1, 1, 8, 8, 8, 0, 0};
    localparam logic [3:0] V4 [8] = '{0, 0, 0, 0, 1, 1, 8, 8};
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        int p;
        checks++;
        if (act !== exp) begin
            errors++;
            p = 0;
            for (int i = DW/32 - 1; i >= 0; i--)
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) p = i;
            $display("FAIL %s cyc=%0d word%0d got=%h want=%h",
                     nm, cyc, p, act[p*32 +: 32], exp[p*32 +: 32]);
        end
    endtask

    // operands and FMA results change every cycle
    initial begin
        mode_in = '0; a_in = '0; b_in = '0; fma_out = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < $bits(a_in)/32; i++) begin
                a_in[i*32 +: 32] = $urandom;
                b_in[i*32 +: 32] = $urandom;
            end
            for (int i = 0; i < $bits(mode_in)/32; i++)
                mode_in[i*32 +: 32] = $urandom;
            for (int i = 0; i < DW/32; i++)
                fma_out[i*32 +: 32] = $urandom;
        end
    end

    // per-cycle model and compare, sampled mid-cycle
    always @(negedge clk) begin
        logic [N_REQ-1:0] e_g, e_rv;
        logic [MW-1:0]    e_m;
        logic [DW-1:0]    e_a, e_b;
        bit               e_busy, iss_now, rearb;
        int               w, o;
        if (!rst_n) begin
            m_own = -1; m_left = 0; m_ptr = N_REQ - 1; m_rsp = '0;
            for (int i = 0; i < 8; i++) iss_r[i] = -1;
            chk("m_gnt", DW'(gnt), '0);
            chk("m_busy", DW'(busy), '0);
            chk("m_rv", DW'(rsp_valid), '0);
            chk("m_data", rsp_data, '0);
            chk("m_a", fma_a, '0);
        end else begin
            e_g = '0; e_m = '0; e_a = '0; e_b = '0; iss_now = 0;
            if (m_own >= 0) begin
                e_g = N_REQ'(1) << m_own;
                if (((req >> m_own) & 1) != 0) begin
                    iss_now = 1;
                    e_m = MW'(mode_in >> (m_own*MW));
                    e_a = DW'(a_in >> (m_own*DW));
                    e_b = DW'(b_in >> (m_own*DW));
                end
            end
            e_rv = '0;
            o = iss_r[(cyc - FMA_LAT - 1) % 8];
            if (o >= 0) begin
                e_rv  = N_REQ'(1) << o;
                m_rsp = fo_r[(cyc - 1) % 8];
            end
            e_busy = (m_own >= 0);
            for (int k = 1; k <= FMA_LAT; k++)
                if (iss_r[(cyc - k) % 8] >= 0) e_busy = 1;
            chk("m_gnt", DW'(gnt), DW'(e_g));
            chk("m_busy", DW'(busy), DW'(e_busy));
            chk("m_mode", DW'(fma_mode), DW'(e_m));
            chk("m_a", fma_a, e_a);
            chk("m_b", fma_b, e_b);
            chk("m_rv", DW'(rsp_valid), DW'(e_rv));
            chk("m_data", rsp_data, m_rsp);
            fo_r[cyc % 8]  = fma_out;
            iss_r[cyc % 8] = iss_now ? m_own : -1;
            // what the upcoming edge must do
            rearb = (m_own < 0) || !iss_now;
            if (iss_now) begin
                m_left--;
                if (m_left == 0) rearb = 1;
            end
            if (rearb) begin
                w = -1;
`ifdef FMA_ARB_FIXED_PRIO_EN
                for (int i = 0; i < N_REQ; i++)
                    if (w < 0 && ((req >> i) & 1) != 0) w = i;
`else
                for (int k = 1; k <= N_REQ; k++)
                    if (w < 0 && ((req >> ((m_ptr + k) % N_REQ)) & 1) != 0)
                        w = (m_ptr + k) % N_REQ;
`endif
                m_own = w;
                if (w >= 0) begin
                    m_left = int'(4'(hold_len >> (4*w))) + 1;
                    m_ptr  = w;
                end
            end
        end
    end

    task automatic cyc_start();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_hold(input int i, input int v);
        hold_len[4*i +: 4] = 4'(v);
    endtask

    task automatic do_reset();
        cyc_start();
        rst_n = 0; req = '0; hold_len = '0;
        mid();
        chk("rst_gnt", DW'(gnt), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_rv", DW'(rsp_valid), '0);
        chk("rst_data", rsp_data, '0);
        chk("rst_mode", DW'(fma_mode), '0);
        repeat (2) cyc_start();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin iss_r[i] = -1; fo_r[i] = '0; end
        rst_n = 0; req = '0; hold_len = '0;

        // single requester, back-to-back re-grant
        do_reset();
        req = 4'b0010; set_hold(1, 2);
        for (int k = 0; k < 7; k++) begin
            mid();
            chk("t1_gnt", DW'(gnt), DW'(G1[k]));
            chk("t1_rv", DW'(rsp_valid), DW'(V1[k]));
            cyc_start();
        end
        req = '0;
        repeat (10) cyc_start();
        mid();
        chk("idle_busy", DW'(busy), '0);
        chk("idle_a", fma_a, '0);
        chk("idle_b", fma_b, '0);
        chk("idle_mode", DW'(fma_mode), '0);

        // full contention, single-cycle bursts
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("t2_gnt", DW'(gnt), DW'(G2[k]));
            cyc_start();
        end
        req = '0;

        // early release then handover
        do_reset();
        req = 4'b0100; set_hold(2, 7);
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("t3_gnt", DW'(gnt), DW'(G3[k]));
            chk("t3_rv", DW'(rsp_valid), DW'(V3[k]));
            cyc_start();
            if (k == 0) req[0] = 1'b1;
            if (k == 3) req[2] = 1'b0;
        end
        req = '0;

        // handover ordering between two bursts
        do_reset();
        req = 4'b1001; set_hold(0, 1); set_hold(3, 1);
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("t4_gnt", DW'(gnt), DW'(G4[k]));
            chk("t4_rv", DW'(rsp_valid), DW'(V4[k]));
            cyc_start();
            if (k == 2) req[0] = 1'b0;
            if (k == 4) req[3] = 1'b0;
        end
        req = '0;

        // reset in the middle of a 4-cycle burst
        do_reset();
        req = 4'b0001; set_hold(0, 3);
        mid(); chk("t5_gnt0", DW'(gnt), '0); cyc_start();
        mid(); chk("t5_gnt1", DW'(gnt), DW'(4'b0001)); cyc_start();
        rst_n = 0; req = 4'b1001;
        #1;
        chk("t5_gnt_now", DW'(gnt), '0);
        chk("t5_busy_now", DW'(busy), '0);
        chk("t5_rv_now", DW'(rsp_valid), '0);
        chk("t5_a_now", fma_a, '0);
        chk("t5_b_now", fma_b, '0);
        chk("t5_mode_now", DW'(fma_mode), '0);
        cyc_start();
        cyc_start();
        rst_n = 1;
        for (int k = 4; k < 8; k++) begin
            mid();
            chk("t5_rv", DW'(rsp_valid), '0);
            if (k == 4) chk("t5_gnt4", DW'(gnt), '0);
            if (k == 5) chk("t5_gnt5", DW'(gnt), DW'(4'b0001));
            cyc_start();
        end
        req = '0;

        // randomized traffic; requesters hold req until granted
        for (int n = 0; n < 2000; n++) begin
            cyc_start();
            for (int i = 0; i < N_REQ; i++) begin
                if (i == m_own && req[i] && $urandom_range(0, 9) == 0)
                    req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0)
                    req[i] = 1'b1;
                set_hold(i, ($urandom_range(0, 1) == 0) ?
                         $urandom_range(0, 3) : $urandom_range(0, 15));
            end
        end

        req = '0;
        for (int n = 0; n < 60; n++) begin
            cyc_start();
            mid();
            if (!busy) break;
        end
        chk("drain_busy", DW'(busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
